// File: rtl/timer_intc_bridge_pkg.sv
// Shared address map, register indices and interrupt source ids for the
// timer / interrupt-controller bridge.
package timer_intc_bridge_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned NUM_SRC   = 3;
    localparam int unsigned WIN_WORDS = 3;
    localparam int unsigned ID_W      = 3;
    localparam int unsigned HWINT_W   = 6;

    localparam logic [ADDR_W-1:0] TIMER0_BASE = 32'h0000_7F00;
    localparam logic [ADDR_W-1:0] TIMER1_BASE = 32'h0000_7F10;
    localparam logic [ADDR_W-1:0] INTC_BASE   = 32'h0000_7F20;

    // Controller registers by word index (byte offsets 0, 4, 8)
    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_CLAIM   = 2'd2;

    localparam int unsigned SRC_T0  = 0;
    localparam int unsigned SRC_T1  = 1;
    localparam int unsigned SRC_EXT = 2;

    localparam logic [ID_W-1:0] CLAIM_NONE = 3'd7;

    typedef struct packed {
        logic t0;
        logic t1;
        logic intc;
    } win_sel_t;

    // Window hit: upper address bits match the base, word index inside the window, word aligned
    function automatic logic win_hit(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base);
        return (addr[ADDR_W-1:4] == base[ADDR_W-1:4])
            && (addr[3:2] < 2'(WIN_WORDS))
            && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/timer_intc_bridge_irq_pending_unit.sv
// Interrupt edge detection, pending/mask registers, claim priority encoder
// and the CP0 HWInt vector.
module timer_intc_bridge_irq_pending_unit
    import timer_intc_bridge_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_SRC-1:0]    src,
    input  logic                  w1c_en,
    input  logic [NUM_SRC-1:0]    w1c_data,
    input  logic                  mask_we,
    input  logic [NUM_SRC-1:0]    mask_wdata,
    input  logic                  claim_en,
    output logic [NUM_SRC-1:0]    pending,
    output logic [NUM_SRC-1:0]    mask,
    output logic                  claim_any,
    output logic [ID_W-1:0]       claim_id,
    output logic [HWINT_W-1:0]    hw_int
);

    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] claim_clr;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] pending_d;

    assign rise   = src & ~src_q;
    assign active = pending & mask;

    // Lowest-numbered active source wins
    always_comb begin
        claim_any = 1'b0;
        claim_id  = CLAIM_NONE;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                claim_any = 1'b1;
                claim_id  = ID_W'(i);
            end
        end
    end

    always_comb begin
        claim_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (claim_en && claim_any && (claim_id == ID_W'(i))) begin
                claim_clr[i] = 1'b1;
            end
        end
    end

    // A rising edge in the same cycle as a clear keeps the bit set
    always_comb begin
        clr       = claim_clr | (w1c_en ? w1c_data : '0);
        pending_d = (pending & ~clr) | rise;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q   <= '0;
            pending <= '0;
            mask    <= '0;
        end else begin
            src_q   <= src;
            pending <= pending_d;
            if (mask_we) begin
                mask <= mask_wdata;
            end
        end
    end

    assign hw_int = {(HWINT_W - NUM_SRC)'(0), active};

endmodule

// File: rtl/timer_intc_bridge.sv
// CPU data-port bridge: decodes the two timer windows and the interrupt
// controller, routes writes, returns registered read data and flags bad accesses.
module timer_intc_bridge
    import timer_intc_bridge_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic [DATA_W-1:0]    cpu_wdata,
    input  logic                 cpu_we,
    input  logic                 cpu_re,
    output logic [DATA_W-1:0]    cpu_rdata,
    output logic                 cpu_rvalid,
    output logic                 bus_err,
    output logic [1:0]           dev_addr,
    output logic [DATA_W-1:0]    dev_wdata,
    output logic                 t0_we,
    output logic                 t1_we,
    input  logic [DATA_W-1:0]    t0_rdata,
    input  logic [DATA_W-1:0]    t1_rdata,
    input  logic                 t0_irq,
    input  logic                 t1_irq,
    input  logic                 ext_irq,
    output logic [HWINT_W-1:0]   hw_int
);

    win_sel_t           sel;
    logic               mapped;
    logic               rd_acc;
    logic [1:0]         word_idx;
    logic [NUM_SRC-1:0] src;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic               claim_any;
    logic [ID_W-1:0]    claim_id;
    logic               intc_w1c;
    logic               intc_mask_we;
    logic               intc_claim;
    logic [DATA_W-1:0]  rd_mux;

    assign word_idx = cpu_addr[3:2];

    always_comb begin
        sel.t0   = win_hit(cpu_addr, TIMER0_BASE);
        sel.t1   = win_hit(cpu_addr, TIMER1_BASE);
        sel.intc = win_hit(cpu_addr, INTC_BASE);
    end

    assign mapped = sel.t0 | sel.t1 | sel.intc;
    // A simultaneous store and load is handled as a store only
    assign rd_acc = cpu_re & ~cpu_we;

    assign dev_addr  = word_idx;
    assign dev_wdata = cpu_wdata;
    assign t0_we     = cpu_we & sel.t0;
    assign t1_we     = cpu_we & sel.t1;

    assign intc_w1c     = cpu_we & sel.intc & (word_idx == REG_PENDING);
    assign intc_mask_we = cpu_we & sel.intc & (word_idx == REG_MASK);
    assign intc_claim   = rd_acc & sel.intc & (word_idx == REG_CLAIM);

    always_comb begin
        src          = '0;
        src[SRC_T0]  = t0_irq;
        src[SRC_T1]  = t1_irq;
        src[SRC_EXT] = ext_irq;
    end

    timer_intc_bridge_irq_pending_unit u_irq (
        .clk        (clk),
        .reset      (reset),
        .src        (src),
        .w1c_en     (intc_w1c),
        .w1c_data   (cpu_wdata[NUM_SRC-1:0]),
        .mask_we    (intc_mask_we),
        .mask_wdata (cpu_wdata[NUM_SRC-1:0]),
        .claim_en   (intc_claim),
        .pending    (pending),
        .mask       (mask),
        .claim_any  (claim_any),
        .claim_id   (claim_id),
        .hw_int     (hw_int)
    );

    // Read data select; claim data reflects pending before this edge's clear
    always_comb begin
        rd_mux = '0;
        if (sel.t0) begin
            rd_mux = t0_rdata;
        end else if (sel.t1) begin
            rd_mux = t1_rdata;
        end else if (sel.intc) begin
            case (word_idx)
                REG_PENDING: rd_mux = {(DATA_W - NUM_SRC)'(0), pending};
                REG_MASK:    rd_mux = {(DATA_W - NUM_SRC)'(0), mask};
                REG_CLAIM:   rd_mux = {(DATA_W - ID_W - 1)'(0), claim_any, claim_id};
                default:     rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            cpu_rvalid <= rd_acc & mapped;
            bus_err    <= (cpu_we | cpu_re) & ~mapped;
            if (rd_acc && mapped) begin
                cpu_rdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_timer_intc_bridge.sv
// Self-checking bench for timer_intc_bridge: behavioural timer register files,
// read-data scoreboard, per-feature test tasks.
module tb_timer_intc_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        bus_err;
    logic [1:0]  dev_addr;
    logic [31:0] dev_wdata;
    logic        t0_we;
    logic        t1_we;
    logic [31:0] t0_rdata;
    logic [31:0] t1_rdata;
    logic        t0_irq;
    logic        t1_irq;
    logic        ext_irq;
    logic [5:0]  hw_int;

    int assertions = 0;
    int failures   = 0;
    logic [31:0] exp_q[$];

    logic [31:0] t0_regs [0:1];
    logic [31:0] t1_regs [0:1];
    localparam logic [31:0] T0_COUNT = 32'h0000_C0DE;
    localparam logic [31:0] T1_COUNT = 32'h0000_BEEF;

    always #5 clk = ~clk;

    timer_intc_bridge dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_we     (cpu_we),
        .cpu_re     (cpu_re),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .bus_err    (bus_err),
        .dev_addr   (dev_addr),
        .dev_wdata  (dev_wdata),
        .t0_we      (t0_we),
        .t1_we      (t1_we),
        .t0_rdata   (t0_rdata),
        .t1_rdata   (t1_rdata),
        .t0_irq     (t0_irq),
        .t1_irq     (t1_irq),
        .ext_irq    (ext_irq),
        .hw_int     (hw_int)
    );

    // Minimal timer models: CTRL and PRESET writable, COUNT fixed
    always @(posedge clk) begin
        if (t0_we && dev_addr < 2'd2) t0_regs[dev_addr[0]] <= dev_wdata;
        if (t1_we && dev_addr < 2'd2) t1_regs[dev_addr[0]] <= dev_wdata;
    end

    always_comb begin
        t0_rdata = 32'h0;
        t1_rdata = 32'h0;
        if (dev_addr < 2'd2) begin
            t0_rdata = t0_regs[dev_addr[0]];
            t1_rdata = t1_regs[dev_addr[0]];
        end else if (dev_addr == 2'd2) begin
            t0_rdata = T0_COUNT;
            t1_rdata = T1_COUNT;
        end
    end

    // Scoreboard consumer: every rvalid must match the oldest expected read
    always @(posedge clk) begin
        #1;
        if (cpu_rvalid) begin
            assertions++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rvalid_unexpected: rvalid=1 rdata=%h with no read outstanding", cpu_rdata);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (cpu_rdata !== e) begin
                    failures++;
                    $display("FAIL read_data: got %h expected %h", cpu_rdata, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic access(input logic we, input logic re, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic o_t0we, output logic o_t1we,
                          output logic [1:0] o_da, output logic o_err);
        @(negedge clk);
        cpu_we = we; cpu_re = re; cpu_addr = addr; cpu_wdata = wdata;
        #1;
        o_t0we = t0_we; o_t1we = t1_we; o_da = dev_addr;
        @(posedge clk);
        #1;
        o_err = bus_err;
        cpu_we = 1'b0; cpu_re = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic a, b, e; logic [1:0] d;
        access(1'b1, 1'b0, addr, data, a, b, d, e);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] expv);
        logic a, b, e; logic [1:0] d;
        exp_q.push_back(expv);
        access(1'b0, 1'b1, addr, 32'h0, a, b, d, e);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        assertions += 4;
        if (cpu_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", cpu_rdata); end
        if (cpu_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid: got %b expected 0", cpu_rvalid); end
        if (bus_err !== 1'b0) begin failures++; $display("FAIL reset_bus_err: got %b expected 0", bus_err); end
        if (hw_int !== 6'h0) begin failures++; $display("FAIL reset_hw_int: got %b expected 0", hw_int); end
    endtask

    task automatic test_timer0();
        logic a, b, e; logic [1:0] d;
        access(1'b1, 1'b0, 32'h7F00, 32'h9, a, b, d, e);
        assertions += 4;
        if (a !== 1'b1) begin failures++; $display("FAIL t0_write_we: t0_we=%b expected 1", a); end
        if (b !== 1'b0) begin failures++; $display("FAIL t0_write_t1we: t1_we=%b expected 0", b); end
        if (d !== 2'd0) begin failures++; $display("FAIL t0_write_addr: dev_addr=%0d expected 0", d); end
        if (e !== 1'b0) begin failures++; $display("FAIL t0_write_err: bus_err=%b expected 0", e); end
        rd(32'h7F00, 32'h9);
        // COUNT write is forwarded with the strobe, timer keeps its own count
        access(1'b1, 1'b0, 32'h7F08, 32'h5555, a, b, d, e);
        assertions += 2;
        if (a !== 1'b1) begin failures++; $display("FAIL t0_count_we: t0_we=%b expected 1", a); end
        if (d !== 2'd2) begin failures++; $display("FAIL t0_count_addr: dev_addr=%0d expected 2", d); end
        rd(32'h7F08, T0_COUNT);
    endtask

    task automatic test_timer1_read();
        logic a, b, e; logic [1:0] d;
        t1_regs[1] = 32'h64;
        exp_q.push_back(32'h64);
        access(1'b0, 1'b1, 32'h7F14, 32'h0, a, b, d, e);
        assertions += 3;
        if (a !== 1'b0 || b !== 1'b0) begin failures++; $display("FAIL t1_read_we: t0_we=%b t1_we=%b expected 0 0", a, b); end
        if (d !== 2'd1) begin failures++; $display("FAIL t1_read_addr: dev_addr=%0d expected 1", d); end
        if (e !== 1'b0) begin failures++; $display("FAIL t1_read_err: bus_err=%b expected 0", e); end
    endtask

    task automatic test_unmapped();
        logic [31:0] addrs [0:3];
        logic        wes   [0:3];
        logic a, b, e; logic [1:0] d;
        addrs[0] = 32'h7F0C; wes[0] = 1'b0;
        addrs[1] = 32'h7F02; wes[1] = 1'b0;
        addrs[2] = 32'h7F2C; wes[2] = 1'b1;
        addrs[3] = 32'h7F31; wes[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            access(wes[i], ~wes[i], addrs[i], 32'hFFFF_FFFF, a, b, d, e);
            assertions += 3;
            if (a !== 1'b0 || b !== 1'b0) begin failures++; $display("FAIL unmapped_we[%0d]: t0_we=%b t1_we=%b expected 0 0", i, a, b); end
            if (e !== 1'b1) begin failures++; $display("FAIL unmapped_err[%0d]: bus_err=%b expected 1", i, e); end
            if (cpu_rdata !== 32'h64) begin failures++; $display("FAIL unmapped_rdata[%0d]: got %h expected 64", i, cpu_rdata); end
        end
        @(posedge clk); #1;
        assertions++;
        if (bus_err !== 1'b0) begin failures++; $display("FAIL bus_err_one_cycle: bus_err=%b expected 0", bus_err); end
    endtask

    task automatic test_claim();
        wr(32'h7F24, 32'h3);
        rd(32'h7F28, 32'h7);
        @(negedge clk); t1_irq = 1'b1;
        @(posedge clk); #1;
        assertions++;
        if (hw_int !== 6'b000010) begin failures++; $display("FAIL claim_hw_int: got %b expected 000010", hw_int); end
        t1_irq = 1'b0;
        rd(32'h7F20, 32'h2);
        rd(32'h7F28, 32'h9);
        rd(32'h7F20, 32'h0);
        assertions++;
        if (hw_int !== 6'h0) begin failures++; $display("FAIL claim_clear_hw_int: got %b expected 0", hw_int); end
        // Masked source latches but does not reach hw_int
        @(negedge clk); ext_irq = 1'b1;
        @(posedge clk); #1;
        ext_irq = 1'b0;
        assertions++;
        if (hw_int !== 6'h0) begin failures++; $display("FAIL masked_hw_int: got %b expected 0", hw_int); end
        rd(32'h7F20, 32'h4);
        rd(32'h7F28, 32'h7);
        wr(32'h7F20, 32'h4);
        rd(32'h7F20, 32'h0);
    endtask

    task automatic test_set_wins();
        t0_irq = 1'b1;
        wr(32'h7F20, 32'h1);
        rd(32'h7F20, 32'h1);
        assertions++;
        if (hw_int !== 6'b000001) begin failures++; $display("FAIL set_wins_hw_int: got %b expected 000001", hw_int); end
        wr(32'h7F20, 32'h1);
        rd(32'h7F20, 32'h0);
        t0_irq = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic a, b, e; logic [1:0] d;
        access(1'b1, 1'b1, 32'h7F24, 32'h5, a, b, d, e);
        rd(32'h7F24, 32'h5);
        rd(32'h7F00, 32'h9);
        rd(32'h7F14, 32'h64);
        rd(32'h7F28, 32'h7);
    endtask

    task automatic test_reset_mid();
        wr(32'h7F24, 32'h7);
        @(negedge clk);
        t0_irq = 1'b1; ext_irq = 1'b1;
        reset = 1'b1;
        cpu_re = 1'b1; cpu_addr = 32'h7F24;
        @(posedge clk); #1;
        reset = 1'b0; cpu_re = 1'b0;
        t0_irq = 1'b0; ext_irq = 1'b0;
        assertions += 4;
        if (cpu_rvalid !== 1'b0) begin failures++; $display("FAIL mid_reset_rvalid: got %b expected 0", cpu_rvalid); end
        if (cpu_rdata !== 32'h0) begin failures++; $display("FAIL mid_reset_rdata: got %h expected 0", cpu_rdata); end
        if (bus_err !== 1'b0) begin failures++; $display("FAIL mid_reset_bus_err: got %b expected 0", bus_err); end
        if (hw_int !== 6'h0) begin failures++; $display("FAIL mid_reset_hw_int: got %b expected 0", hw_int); end
        rd(32'h7F20, 32'h0);
        rd(32'h7F24, 32'h0);
    endtask

    initial begin
        reset = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_re = 1'b0;
        t0_irq = 1'b0; t1_irq = 1'b0; ext_irq = 1'b0;
        t0_regs[0] = '0; t0_regs[1] = '0; t1_regs[0] = '0; t1_regs[1] = '0;
        test_reset();
        test_timer0();
        test_timer1_read();
        test_unmapped();
        test_claim();
        test_set_wins();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge clk);
        #2;
        assertions++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d reads outstanding expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
